// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin grant, registered write stage and a
// pending-write scoreboard. Define RFARB_FIXED_PRIO_EN for lowest-index-wins priority.
module regfile_write_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic [31:0]          busy_mask,
    output logic                 rf_w_en,
    output logic [AW-1:0]        rf_req_w,
    output logic [DW-1:0]        rf_data_w
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] gidx;
    logic          hit;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data;
    logic          w_en_q;
    logic [AW-1:0] req_w_q;
    logic [DW-1:0] data_w_q;
    logic [31:0]   busy_q, busy_d;

`ifdef RFARB_FIXED_PRIO_EN
    always_comb begin
        gidx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) gidx = PW'(i);
        end
    end
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;

    // Search upward from rr_ptr, wrapping modulo NREQ; first valid wins.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        gidx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hit) rr_ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign hit       = en && !rst && (|req_valid);
    assign req_ready = hit ? (NREQ'(1) << gidx) : '0;
    assign acc_addr  = req_addr[gidx*AW +: AW];
    assign acc_data  = req_data[gidx*DW +: DW];

    // Retire clears only after the write stage has been visible for a full cycle;
    // a same-edge reservation of that register takes precedence.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < 32; r++) begin
            if (w_en_q && req_w_q == AW'(r)) busy_d[r] = 1'b0;
            if (en && rsv_valid && rsv_addr == AW'(r)) busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_en_q   <= 1'b0;
            req_w_q  <= '0;
            data_w_q <= '0;
            busy_q   <= '0;
        end else begin
            w_en_q <= hit && (acc_addr != '0);
            if (hit) begin
                req_w_q  <= acc_addr;
                data_w_q <= acc_data;
            end
            busy_q <= busy_d;
        end
    end

    assign busy_mask = busy_q;
    assign rf_w_en   = w_en_q;
    assign rf_req_w  = req_w_q;
    assign rf_data_w = data_w_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued when a grant is
// expected and retired by a monitor at each negedge where rf_w_en is high.
module tb_regfile_write_arbiter;
    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en  = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic                rsv_valid = 1'b0;
    logic [AW-1:0]       rsv_addr = '0;
    logic [31:0]         busy_mask;
    logic                rf_w_en;
    logic [AW-1:0]       rf_req_w;
    logic [DW-1:0]       rf_data_w;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .busy_mask(busy_mask), .rf_w_en(rf_w_en),
        .rf_req_w(rf_req_w), .rf_data_w(rf_data_w)
    );

    always #5 clk = ~clk;

    // Register-file side: each write is committed at the negedge inside its cycle.
    always @(negedge clk) begin
        if (!rst && rf_w_en) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", rf_req_w, rf_data_w);
            end else begin
                e = exp_q.pop_front();
                if (rf_req_w !== e.addr || rf_data_w !== e.data) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             rf_req_w, rf_data_w, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rf_w_en !== 1'b0 || rf_req_w !== '0 || rf_data_w !== '0 || busy_mask !== 32'h0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got w_en=%b req_w=%0d data=%h busy=%h ready=%b, required all 0",
                     rf_w_en, rf_req_w, rf_data_w, busy_mask, req_ready);
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd4;
        tick();
        rsv_valid = 1'b0;
        set_req(0, 5'd4, 32'h1234_5678);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        checks++;
        if (rf_w_en !== 1'b1 || busy_mask !== 32'h0000_0010) begin
            errors++;
            $display("FAIL midwrite_setup: got w_en=%b busy=%h, required w_en=1 busy=00000010", rf_w_en, busy_mask);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rf_w_en !== 1'b0 || rf_req_w !== '0 || rf_data_w !== '0 || busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL midwrite_reset: got w_en=%b req_w=%0d data=%h busy=%h, required all 0",
                     rf_w_en, rf_req_w, rf_data_w, busy_mask);
        end
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g [4];
`ifdef RFARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        set_req(0, 5'd3, 32'hAAAA_0003);
        set_req(1, 5'd7, 32'hBBBB_0007);
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (req_ready !== exp_g[c]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b, required %b", c, req_ready, exp_g[c]);
            end
            if (exp_g[c] == 2'b01) push(5'd3, 32'hAAAA_0003);
            else                   push(5'd7, 32'hBBBB_0007);
            tick();
        end
        req_valid = '0;
        tick();
        checks++;
        if (exp_q.size() != 0 || busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL rr_drain: got pending=%0d busy=%h, required 0 and 0", exp_q.size(), busy_mask);
        end
    endtask

    task automatic test_scoreboard();
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        tick();
        rsv_valid = 1'b0;
        checks++;
        if (busy_mask !== 32'h0000_0020) begin
            errors++;
            $display("FAIL sb_set: got busy=%h, required 00000020", busy_mask);
        end
        tick();
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL sb_grant: got %b, required 01", req_ready);
        end
        push(5'd5, 32'hDEAD_BEEF);
        tick();
        req_valid = '0;
        checks++;
        if (rf_w_en !== 1'b1 || busy_mask !== 32'h0000_0020) begin
            errors++;
            $display("FAIL sb_inflight: got w_en=%b busy=%h, required w_en=1 busy=00000020", rf_w_en, busy_mask);
        end
        tick();
        checks++;
        if (rf_w_en !== 1'b0 || busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL sb_clear: got w_en=%b busy=%h, required w_en=0 busy=00000000", rf_w_en, busy_mask);
        end
    endtask

    task automatic test_same_edge();
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_valid = 1'b0;
        set_req(0, 5'd9, 32'h0000_0999);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL se_grant: got %b, required 01", req_ready);
        end
        push(5'd9, 32'h0000_0999);
        tick();
        req_valid = '0;
        rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_valid = 1'b0;
        checks++;
        if (busy_mask !== 32'h0000_0200) begin
            errors++;
            $display("FAIL se_set_wins: got busy=%h, required 00000200", busy_mask);
        end
        tick();
        set_req(1, 5'd9, 32'h0000_1999);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL se_grant1: got %b, required 10", req_ready);
        end
        push(5'd9, 32'h0000_1999);
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL se_final_clear: got busy=%h, required 00000000", busy_mask);
        end
    endtask

    task automatic test_r0();
        rsv_valid = 1'b1; rsv_addr = 5'd2;
        tick();
        rsv_addr = 5'd0;
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL r0_grant: got %b, required 01", req_ready);
        end
        tick();
        req_valid = '0;
        rsv_valid = 1'b0;
        checks++;
        if (rf_w_en !== 1'b0 || busy_mask !== 32'h0000_0004 || rf_req_w !== 5'd0) begin
            errors++;
            $display("FAIL r0_drop: got w_en=%b busy=%h req_w=%0d, required w_en=0 busy=00000004 req_w=0",
                     rf_w_en, busy_mask, rf_req_w);
        end
        set_req(1, 5'd2, 32'h2222_2222);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL r0_next_grant: got %b, required 10", req_ready);
        end
        push(5'd2, 32'h2222_2222);
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (busy_mask !== 32'h0) begin
            errors++;
            $display("FAIL r0_cleanup: got busy=%h, required 00000000", busy_mask);
        end
    endtask

    task automatic test_enable();
        logic [NREQ-1:0] exp_resume;
`ifdef RFARB_FIXED_PRIO_EN
        exp_resume = 2'b01;
`else
        exp_resume = 2'b10;
`endif
        rsv_valid = 1'b1; rsv_addr = 5'd6;
        tick();
        rsv_valid = 1'b0;
        set_req(0, 5'd6, 32'h6666_0006);
        req_valid = 2'b01;
        push(5'd6, 32'h6666_0006);
        tick();
        en = 1'b0;
        set_req(0, 5'd3, 32'hAAAA_0003);
        set_req(1, 5'd7, 32'hBBBB_0007);
        req_valid = 2'b11;
        rsv_valid = 1'b1; rsv_addr = 5'd8;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL en_halt_ready%0d: got %b, required 00", c, req_ready);
            end
            tick();
            checks++;
            if (rf_w_en !== 1'b0 || busy_mask !== 32'h0) begin
                errors++;
                $display("FAIL en_halt_state%0d: got w_en=%b busy=%h, required 0 and 00000000", c, rf_w_en, busy_mask);
            end
        end
        rsv_valid = 1'b0;
        en = 1'b1;
        #1;
        checks++;
        if (req_ready !== exp_resume) begin
            errors++;
            $display("FAIL en_resume_grant: got %b, required %b", req_ready, exp_resume);
        end
        if (exp_resume == 2'b10) push(5'd7, 32'hBBBB_0007);
        else                     push(5'd3, 32'hAAAA_0003);
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_scoreboard();
        test_same_edge();
        test_r0();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
